reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core. Replaces the single-write/dual-read negedge file.
- Writes are on the rising edge. Provides:
  - N read ports and M write ports.
  - Optional same-cycle write-to-read bypass.
  - Per-register busy scoreboard for hazard detection in decode.
  - Asynchronous active-low clear of all state.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/riscv_rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 79 +++++++
 rtl/reg_file_mp.sv | 115 +++++++++++
 tb/tb_reg_file_mp.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// Shared constants and types for the integer register file slice.
// Default widths and ABI register indices used by the file and its users.
package riscv_rf_pkg;

    localparam int RF_D_WIDTH    = 32;
    localparam int RF_ADDR_WIDTH = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins.
// Also produces the per-read-port busy view, including forwarding effects.
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD        = 3,
    parameter int NUM_WR        = 2,
    parameter int BYPASS        = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    input  logic                            issue_en,
    input  logic [ADDRESS_WIDTH-1:0]        issue_addr,
    output logic [NUM_RD-1:0]               rd_busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clr_s;
    logic [NUM_RD-1:0] rd_busy_s;

    // Decode issue and writeback indices into one-hot set/clear vectors.
    always_comb begin
        set_s = {DEPTH{1'b0}};
        clr_s = {DEPTH{1'b0}};
        if (issue_en) begin
            set_s[issue_addr] = 1'b1;
        end else begin
            set_s = {DEPTH{1'b0}};
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                clr_s[wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
            end else begin
                clr_s[0] = clr_s[0];
            end
        end
    end

    // Next busy state: a new producer supersedes a completing one; x0 never busy.
    always_comb begin
        busy_nxt_s    = (busy_r & ~clr_s) | set_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Read-port busy view: forwarded data hides busy unless re-issued this cycle.
    always_comb begin
        rd_busy_s = {NUM_RD{1'b0}};
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH] == {ADDRESS_WIDTH{1'b0}}) begin
                rd_busy_s[r] = 1'b0;
            end else if ((BYPASS != 0) && clr_s[rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]]
                         && !set_s[rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]]) begin
                rd_busy_s[r] = 1'b0;
            end else begin
                rd_busy_s[r] = busy_r[rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
            end
        end
    end

    assign rd_busy = rd_busy_s;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// collision flag and a busy scoreboard for decode hazard detection.
module reg_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int D_WIDTH       = RF_D_WIDTH,
    parameter int ADDRESS_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD        = 3,
    parameter int NUM_WR        = 2,
    parameter int BYPASS        = 1,
    parameter int DEBUG_REG     = REG_A0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*D_WIDTH-1:0]       wr_data,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*D_WIDTH-1:0]       rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic                            issue_en,
    input  logic [ADDRESS_WIDTH-1:0]        issue_addr,
    output logic                            wr_conflict,
    output logic [D_WIDTH-1:0]              dbg_reg
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [D_WIDTH-1:0]        regs_r [DEPTH];
    logic                      wr_conflict_r;
    logic                      conflict_s;
    logic [NUM_RD*D_WIDTH-1:0] rd_data_s;

    // Storage update: later ports overwrite earlier ones, so the highest port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {D_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] != {ADDRESS_WIDTH{1'b0}})) begin
                    regs_r[wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= wr_data[k*D_WIDTH +: D_WIDTH];
                end
            end
        end
    end

    // Detect two enabled writes aimed at the same nonzero register.
    always_comb begin
        conflict_s = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_en[a] && wr_en[b]
                    && (wr_addr[a*ADDRESS_WIDTH +: ADDRESS_WIDTH] == wr_addr[b*ADDRESS_WIDTH +: ADDRESS_WIDTH])
                    && (wr_addr[a*ADDRESS_WIDTH +: ADDRESS_WIDTH] != {ADDRESS_WIDTH{1'b0}})) begin
                    conflict_s = 1'b1;
                end else begin
                    conflict_s = conflict_s;
                end
            end
        end
    end

    // Collision flag register, held for exactly the cycle after the collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= conflict_s;
        end
    end

    // Read mux: stored value, overridden by the highest matching write when bypassing.
    always_comb begin
        rd_data_s = {(NUM_RD*D_WIDTH){1'b0}};
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_s[r*D_WIDTH +: D_WIDTH] = regs_r[rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
            for (int k = 0; k < NUM_WR; k++) begin
                if ((BYPASS != 0) && wr_en[k]
                    && (wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] == rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
                    rd_data_s[r*D_WIDTH +: D_WIDTH] = wr_data[k*D_WIDTH +: D_WIDTH];
                end else begin
                    rd_data_s[r*D_WIDTH +: D_WIDTH] = rd_data_s[r*D_WIDTH +: D_WIDTH];
                end
            end
            if (rd_addr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH] == {ADDRESS_WIDTH{1'b0}}) begin
                rd_data_s[r*D_WIDTH +: D_WIDTH] = {D_WIDTH{1'b0}};
            end else begin
                rd_data_s[r*D_WIDTH +: D_WIDTH] = rd_data_s[r*D_WIDTH +: D_WIDTH];
            end
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_RD        (NUM_RD),
        .NUM_WR        (NUM_WR),
        .BYPASS        (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_busy    (rd_busy)
    );

    assign rd_data     = rd_data_s;
    assign wr_conflict = wr_conflict_r;
    assign dbg_reg     = regs_r[DEBUG_REG];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance
// share the same stimulus so forwarding behaviour can be compared directly.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;

    logic              clk;
    logic              rst_n;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;

    logic [NR*DW-1:0]  rd_data_b,  rd_data_n;
    logic [NR-1:0]     rd_busy_b,  rd_busy_n;
    logic              wr_conflict_b, wr_conflict_n;
    logic [DW-1:0]     dbg_reg_b,  dbg_reg_n;

    int checks   = 0;
    int failures = 0;

    reg_file_mp #(.D_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(1), .DEBUG_REG(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wr_conflict(wr_conflict_b), .dbg_reg(dbg_reg_b)
    );

    reg_file_mp #(.D_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(0), .DEBUG_REG(10)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wr_conflict(wr_conflict_n), .dbg_reg(dbg_reg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_en      = 2'b00;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rd_addr = '0;
        #12;
        checks++;
        if (wr_conflict_b !== 1'b0) begin
            failures++; $display("FAIL reset_conflict got=%0b exp=0", wr_conflict_b);
        end
        checks++;
        if (dbg_reg_b !== 32'h0) begin
            failures++; $display("FAIL reset_dbg got=%h exp=0", dbg_reg_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr = {i[4:0], i[4:0], i[4:0]};
            #1;
            checks++;
            if (rd_data_b !== 96'h0 || rd_busy_b !== 3'b000) begin
                failures++; $display("FAIL reset_read idx=%0d data=%h busy=%b exp=0", i, rd_data_b, rd_busy_b);
            end
        end
        // Commit x5 = 0xDEAD, then pull reset in the middle of the next cycle.
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h0000_DEAD};
        rd_addr = {5'd0, 5'd0, 5'd5};
        @(posedge clk); #1;
        idle_inputs();
        #1;
        checks++;
        if (rd_data_n[31:0] !== 32'h0000_DEAD) begin
            failures++; $display("FAIL pre_reset_x5 got=%h exp=0000dead", rd_data_n[31:0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
            failures++; $display("FAIL async_reset_x5 got=%h/%h exp=0", rd_data_b[31:0], rd_data_n[31:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234_5678};
        rd_addr = {5'd0, 5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data_b[31:0] !== 32'h1234_5678) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=12345678", rd_data_b[31:0]);
        end
        checks++;
        if (rd_data_n[31:0] !== 32'h0) begin
            failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rd_data_n[31:0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_data_b[31:0] !== 32'h1234_5678 || rd_data_n[31:0] !== 32'h1234_5678) begin
            failures++; $display("FAIL write_stored got=%h/%h exp=12345678", rd_data_b[31:0], rd_data_n[31:0]);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        issue_en = 1'b1; issue_addr = 5'd0;
        rd_addr = {5'd0, 5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data_b !== 96'h0 || rd_busy_b !== 3'b000) begin
            failures++; $display("FAIL x0_same_cycle data=%h busy=%b exp=0", rd_data_b, rd_busy_b);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_data_b !== 96'h0 || rd_busy_b !== 3'b000 || wr_conflict_b !== 1'b0) begin
            failures++; $display("FAIL x0_after data=%h busy=%b conflict=%b exp=0", rd_data_b, rd_busy_b, wr_conflict_b);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h0000_BBBB, 32'h0000_AAAA};
        rd_addr = {5'd0, 5'd0, 5'd7};
        #1;
        checks++;
        if (rd_data_b[31:0] !== 32'h0000_BBBB) begin
            failures++; $display("FAIL collision_bypass got=%h exp=0000bbbb", rd_data_b[31:0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (wr_conflict_b !== 1'b1 || wr_conflict_n !== 1'b1) begin
            failures++; $display("FAIL conflict_set got=%b/%b exp=1", wr_conflict_b, wr_conflict_n);
        end
        checks++;
        if (rd_data_n[31:0] !== 32'h0000_BBBB) begin
            failures++; $display("FAIL collision_winner got=%h exp=0000bbbb", rd_data_n[31:0]);
        end
        @(negedge clk);
        checks++;
        if (wr_conflict_b !== 1'b0) begin
            failures++; $display("FAIL conflict_clear got=%b exp=0", wr_conflict_b);
        end
        // Two ports to distinct registers must not flag a collision.
        wr_en = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {32'h9, 32'h8};
        @(negedge clk);
        idle_inputs();
        checks++;
        if (wr_conflict_b !== 1'b0) begin
            failures++; $display("FAIL conflict_distinct got=%b exp=0", wr_conflict_b);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd3;
        rd_addr = {5'd0, 5'd3, 5'd0};
        #1;
        checks++;
        if (rd_busy_b[1] !== 1'b0) begin
            failures++; $display("FAIL busy_issue_cycle got=%b exp=0", rd_busy_b[1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_b[1] !== 1'b1 || rd_busy_n[1] !== 1'b1) begin
            failures++; $display("FAIL busy_set got=%b/%b exp=1", rd_busy_b[1], rd_busy_n[1]);
        end
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h42};
        issue_en = 1'b1; issue_addr = 5'd3;
        #1;
        checks++;
        if (rd_busy_b[1] !== 1'b1) begin
            failures++; $display("FAIL busy_wb_plus_issue_comb got=%b exp=1", rd_busy_b[1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_n[1] !== 1'b1 || rd_data_n[63:32] !== 32'h42) begin
            failures++; $display("FAIL busy_issue_wins busy=%b data=%h exp=1/42", rd_busy_n[1], rd_data_n[63:32]);
        end
        wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h55, 32'h0};
        #1;
        checks++;
        if (rd_busy_b[1] !== 1'b0 || rd_busy_n[1] !== 1'b1) begin
            failures++; $display("FAIL busy_forward got=%b/%b exp=0/1", rd_busy_b[1], rd_busy_n[1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_b[1] !== 1'b0 || rd_busy_n[1] !== 1'b0 || rd_data_n[63:32] !== 32'h55) begin
            failures++; $display("FAIL busy_cleared busy=%b/%b data=%h exp=0/0/55", rd_busy_b[1], rd_busy_n[1], rd_data_n[63:32]);
        end
    endtask

    task automatic test_dbg();
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'hCAFE_F00D};
        #1;
        checks++;
        if (dbg_reg_b !== 32'h0) begin
            failures++; $display("FAIL dbg_write_cycle got=%h exp=0", dbg_reg_b);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (dbg_reg_b !== 32'hCAFE_F00D || dbg_reg_n !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL dbg_after got=%h/%h exp=cafef00d", dbg_reg_b, dbg_reg_n);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {5'd12, 5'd0}; wr_data = {32'h11, 32'h0};
        rd_addr = {5'd12, 5'd0, 5'd0};
        @(negedge clk);
        wr_data = {32'h22, 32'h0};
        #1;
        checks++;
        if (rd_data_n[95:64] !== 32'h11 || rd_data_b[95:64] !== 32'h22) begin
            failures++; $display("FAIL b2b_second got=%h/%h exp=11/22", rd_data_n[95:64], rd_data_b[95:64]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_data_n[95:64] !== 32'h22) begin
            failures++; $display("FAIL b2b_final got=%h exp=22", rd_data_n[95:64]);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_collision();
        test_scoreboard();
        test_dbg();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
